// File: rtl/timer_seq_ctrl_pkg.sv
// Shared timer definitions: sequencer state encoding, command opcodes,
// byte-lane helper.
package timer_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_CAP,
    ST_RD,
    ST_RSP
  } state_e;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_READ = 1'b1
  } cmd_op_e;

  // Select byte lane idx (0 = LSB) of a 32-bit word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/timer_irq_track.sv
// Timer interrupt tracking: rising-edge detect, sticky pending flag and
// saturating edge counter, all cleared by irq_clear.
module timer_irq_track (
  input  logic       clk,
  input  logic       rst,
  input  logic       tmr_irq,
  input  logic       irq_clear,
  output logic       irq_pending,
  output logic [7:0] irq_count
);

  logic       irq_prev_q, irq_prev_d;
  logic       pending_q, pending_d;
  logic [7:0] count_q, count_d;
  logic       rise;

  // Edge/pending/count update; a rising edge wins over a coincident clear.
  always_comb begin
    rise       = tmr_irq & ~irq_prev_q;
    irq_prev_d = tmr_irq;
    pending_d  = pending_q;
    count_d    = count_q;
    if (irq_clear) begin
      pending_d = 1'b0;
      count_d   = '0;
    end
    if (rise) begin
      pending_d = 1'b1;
      if (irq_clear) begin
        count_d = 8'd1;
      end else if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  // Tracking registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_prev_q <= 1'b0;
      pending_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
    end
  end

  assign irq_pending = pending_q;
  assign irq_count   = count_q;

endmodule

// File: rtl/timer_seq_ctrl.sv
// Command sequencer for a byte-wide timer: loads a 32-bit compare value as
// four LSB-first write beats, or captures and reads back the 32-bit count.
module timer_seq_ctrl
  import timer_seq_ctrl_pkg::*;
#(
  parameter logic [2:0] WR_ADDR = 3'd0,
  parameter logic [2:0] RD_BASE = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  tmr_addr,
  output logic        tmr_write,
  output logic        tmr_read,
  output logic [7:0]  tmr_wdata,
  input  logic [7:0]  tmr_rdata,
  input  logic        tmr_irq,
  output logic        irq_pending,
  input  logic        irq_clear,
  output logic [7:0]  irq_count
);

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] data_q, data_d;

  // Next-state, datapath and timer-bus outputs; everything is a function of
  // the registered state so the bus is glitch-free relative to the beats.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    data_d    = data_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    tmr_addr  = '0;
    tmr_write = 1'b0;
    tmr_read  = 1'b0;
    tmr_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = rst;
        if (cmd_valid && rst) begin
          beat_d = '0;
          if (cmd_op_e'(cmd_op) == OP_READ) begin
            state_d = ST_RD_CAP;
          end else begin
            data_d  = cmd_data;
            state_d = ST_WR;
          end
        end
      end
      ST_WR: begin
        tmr_write = 1'b1;
        tmr_addr  = WR_ADDR;
        tmr_wdata = byte_sel(data_q, beat_q);
        beat_d    = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = ST_RSP;
      end
      ST_RD_CAP: begin
        tmr_read = 1'b1;
        tmr_addr = RD_BASE;
        state_d  = ST_RD;
      end
      ST_RD: begin
        tmr_addr = RD_BASE + {1'b0, beat_q};
        case (beat_q)
          2'd0:    data_d[7:0]   = tmr_rdata;
          2'd1:    data_d[15:8]  = tmr_rdata;
          2'd2:    data_d[23:16] = tmr_rdata;
          default: data_d[31:24] = tmr_rdata;
        endcase
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
    end
  end

  assign rsp_data = data_q;

  timer_irq_track u_irq (
    .clk         (clk),
    .rst         (rst),
    .tmr_irq     (tmr_irq),
    .irq_clear   (irq_clear),
    .irq_pending (irq_pending),
    .irq_count   (irq_count)
  );

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Self-checking bench for timer_seq_ctrl with a behavioural timer peripheral.
module tb_timer_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  tmr_addr;
  logic        tmr_write, tmr_read;
  logic [7:0]  tmr_wdata, tmr_rdata;
  logic        tmr_irq, irq_pending, irq_clear;
  logic [7:0]  irq_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_seq_ctrl #(.WR_ADDR(3'd0), .RD_BASE(3'd4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tmr_addr(tmr_addr), .tmr_write(tmr_write), .tmr_read(tmr_read),
    .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata),
    .tmr_irq(tmr_irq), .irq_pending(irq_pending), .irq_clear(irq_clear),
    .irq_count(irq_count)
  );

  // Behavioural timer: running count, capture on tmr_read, compare shift-in.
  logic [31:0] tcount, tcap, tcomp, tset_val;
  logic        tset, trun;
  always @(posedge clk) begin
    if (tset) tcount <= tset_val;
    else if (trun) tcount <= tcount + 32'd1;
    if (tmr_read) tcap <= tcount;
    if (tmr_write) tcomp <= {tmr_wdata, tcomp[31:8]};
  end
  always_comb begin
    tmr_rdata = 8'h00;
    case (tmr_addr)
      3'd4: tmr_rdata = tcap[7:0];
      3'd5: tmr_rdata = tcap[15:8];
      3'd6: tmr_rdata = tcap[23:16];
      3'd7: tmr_rdata = tcap[31:24];
      default: tmr_rdata = 8'h00;
    endcase
  end

  // Observations of one command, cycles 1..7 after accept.
  logic [13:0] obs_ctl [1:7];
  logic [31:0] obs_data [1:7];
  logic        obs_ready [1:7];
  logic        obs_acc;
  logic [31:0] cnt_seen;

  // Expected {write, read, addr, wdata, rsp_valid} at cycle k after accept.
  function automatic logic [13:0] exp_ctl(input logic op, input logic [31:0] d, input int k);
    logic [7:0] b;
    if (op == 1'b0) begin
      if (k <= 4) begin
        b = 8'((d >> (8 * (k - 1))) & 32'hFF);
        return {1'b1, 1'b0, 3'd0, b, 1'b0};
      end
      return {1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    end
    if (k == 1) return {1'b0, 1'b1, 3'd4, 8'h00, 1'b0};
    if (k <= 5) return {1'b0, 1'b0, 3'(4 + k - 2), 8'h00, 1'b0};
    return {1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
  endfunction

  task automatic issue_cmd(input logic op, input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    obs_acc = cmd_ready;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_data = $urandom;
      if (k == 1) cnt_seen = tcount;
      obs_ctl[k]   = {tmr_write, tmr_read, tmr_addr, tmr_wdata, rsp_valid};
      obs_data[k]  = rsp_data;
      obs_ready[k] = cmd_ready;
    end
  endtask

  task automatic finish_rsp(input int delay);
    repeat (delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, tmr_addr, tmr_write, tmr_read, tmr_wdata, irq_pending, irq_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h addr=%h wr=%b rdst=%b wd=%h ip=%b ic=%h exp all 0",
               cmd_ready, rsp_valid, rsp_data, tmr_addr, tmr_write, tmr_read, tmr_wdata, irq_pending, irq_count);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_load_directed;
    logic [31:0] d = 32'hA1B2C3D4;
    issue_cmd(1'b0, d);
    checks++;
    if (obs_acc !== 1'b1) begin errors++; $display("FAIL load_accept: got %b exp 1", obs_acc); end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (obs_ctl[k] !== exp_ctl(1'b0, d, k) || obs_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL load_cycle%0d: got ctl=%h rdy=%b exp ctl=%h rdy=0", k, obs_ctl[k], obs_ready[k], exp_ctl(1'b0, d, k));
      end
    end
    checks++;
    if (obs_data[5] !== d) begin errors++; $display("FAIL load_rsp_data: got %h exp %h", obs_data[5], d); end
    checks++;
    if (tcomp !== d) begin errors++; $display("FAIL load_timer_compare: got %h exp %h", tcomp, d); end
    finish_rsp(0);
  endtask

  task automatic test_read_directed;
    trun = 1'b0; tset_val = 32'h0000_1234; tset = 1'b1;
    @(negedge clk); tset = 1'b0;
    issue_cmd(1'b1, 32'hDEAD_BEEF);
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (obs_ctl[k] !== exp_ctl(1'b1, 32'h0, k) || obs_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL read_cycle%0d: got ctl=%h rdy=%b exp ctl=%h rdy=0", k, obs_ctl[k], obs_ready[k], exp_ctl(1'b1, 32'h0, k));
      end
    end
    checks++;
    if (obs_data[6] !== 32'h0000_1234) begin errors++; $display("FAIL read_rsp_data: got %h exp 00001234", obs_data[6]); end
    finish_rsp(0);
  endtask

  task automatic test_hold;
    logic [31:0] d = $urandom;
    issue_cmd(1'b0, d);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1; cmd_op = 1'($urandom); cmd_data = $urandom;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d || cmd_ready !== 1'b0 || tmr_write !== 1'b0 || tmr_read !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: rv=%b rd=%h rdy=%b wr=%b rs=%b exp rv=1 rd=%h rdy=0 wr=0 rs=0",
                 i, rsp_valid, rsp_data, cmd_ready, tmr_write, tmr_read, d);
      end
    end
    cmd_valid = 1'b0;
    finish_rsp(0);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: rv=%b rdy=%b exp rv=0 rdy=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_random_cmds;
    logic op;
    logic [31:0] d, exp_d;
    trun = 1'b1; tset_val = $urandom; tset = 1'b1;
    @(negedge clk); tset = 1'b0;
    for (int n = 0; n < 16; n++) begin
      op = 1'($urandom); d = $urandom;
      issue_cmd(op, d);
      exp_d = op ? cnt_seen : d;
      checks++;
      if (obs_acc !== 1'b1) begin errors++; $display("FAIL rand%0d_accept: got %b exp 1", n, obs_acc); end
      for (int k = 1; k <= 7; k++) begin
        checks++;
        if (obs_ctl[k] !== exp_ctl(op, d, k)) begin
          errors++; $display("FAIL rand%0d_cycle%0d op=%b: got %h exp %h", n, k, op, obs_ctl[k], exp_ctl(op, d, k));
        end
      end
      checks++;
      if (obs_data[7] !== exp_d) begin errors++; $display("FAIL rand%0d_data op=%b: got %h exp %h", n, op, obs_data[7], exp_d); end
      finish_rsp(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_irq_clear;
    irq_clear = 1'b1; @(negedge clk); irq_clear = 1'b0;
    checks++;
    if (irq_pending !== 1'b0 || irq_count !== 8'd0) begin
      errors++; $display("FAIL irq_clear_only: ip=%b ic=%0d exp 0 0", irq_pending, irq_count);
    end
    for (int i = 0; i < 3; i++) begin
      tmr_irq = 1'b1; @(negedge clk); tmr_irq = 1'b0; @(negedge clk);
    end
    checks++;
    if (irq_pending !== 1'b1 || irq_count !== 8'd3) begin
      errors++; $display("FAIL irq_three: ip=%b ic=%0d exp 1 3", irq_pending, irq_count);
    end
    tmr_irq = 1'b1; irq_clear = 1'b1; @(negedge clk);
    tmr_irq = 1'b0; irq_clear = 1'b0;
    checks++;
    if (irq_pending !== 1'b1 || irq_count !== 8'd1) begin
      errors++; $display("FAIL irq_edge_with_clear: ip=%b ic=%0d exp 1 1", irq_pending, irq_count);
    end
  endtask

  // Random irq waveform with occasional clears against an edge-counting model.
  task automatic test_irq_random;
    int  cnt = 0;
    bit  pend = 1'b0, prev = 1'b0, cur, clr;
    irq_clear = 1'b1; @(negedge clk); irq_clear = 1'b0;
    prev = tmr_irq;
    for (int i = 0; i < 120; i++) begin
      cur = 1'($urandom); clr = ($urandom_range(0, 15) == 0);
      tmr_irq = cur; irq_clear = clr;
      @(negedge clk);
      if (clr) begin cnt = 0; pend = 1'b0; end
      if (cur && !prev) begin pend = 1'b1; cnt = (cnt < 255) ? cnt + 1 : 255; end
      prev = cur;
      checks++;
      if (irq_pending !== pend || irq_count !== 8'(cnt)) begin
        errors++; $display("FAIL irq_rand%0d: ip=%b ic=%0d exp %b %0d", i, irq_pending, irq_count, pend, cnt);
      end
    end
    tmr_irq = 1'b0; irq_clear = 1'b0;
  endtask

  task automatic test_irq_saturate;
    irq_clear = 1'b1; @(negedge clk); irq_clear = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tmr_irq = 1'b1; @(negedge clk); tmr_irq = 1'b0; @(negedge clk);
      if (i == 254) begin
        checks++;
        if (irq_count !== 8'hFF) begin errors++; $display("FAIL irq_at_255: got %h exp ff", irq_count); end
      end
    end
    checks++;
    if (irq_count !== 8'hFF || irq_pending !== 1'b1) begin
      errors++; $display("FAIL irq_saturate: ic=%h ip=%b exp ff 1", irq_count, irq_pending);
    end
  endtask

  task automatic test_reset_midload;
    int writes = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 32'h1357_9BDF;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, tmr_addr, tmr_write, tmr_read, tmr_wdata, irq_pending, irq_count} !== '0) begin
      errors++;
      $display("FAIL midload_reset_outputs: rdy=%b rv=%b rd=%h addr=%h wr=%b rs=%b wd=%h ip=%b ic=%h exp all 0",
               cmd_ready, rsp_valid, rsp_data, tmr_addr, tmr_write, tmr_read, tmr_wdata, irq_pending, irq_count);
    end
    for (int i = 0; i < 4; i++) begin
      if (tmr_write) writes++;
      @(negedge clk);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (tmr_write) writes++;
      @(negedge clk);
    end
    checks++;
    if (writes != 0) begin errors++; $display("FAIL midload_no_writes: got %0d exp 0", writes); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midload_recover_ready: got %b exp 1", cmd_ready); end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0;
    rsp_ready = 1'b0; tmr_irq = 1'b0; irq_clear = 1'b0;
    tset = 1'b1; tset_val = '0; trun = 1'b0;
    @(negedge clk); tset = 1'b0;
    test_reset;
    test_load_directed;
    test_read_directed;
    test_hold;
    test_random_cmds;
    test_irq_clear;
    test_irq_random;
    test_irq_saturate;
    test_reset_midload;
    test_load_directed;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-002 Parameter: WR_ADDR, 3'd0, tmr_addr value driven during compare-load write beats.
REQ-003 Parameter: RD_BASE, 3'd4, tmr_addr of count byte 0; bytes 1..3 SHALL use RD_BASE+1..RD_BASE+3.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 cmd_op  in  1  0 = load compare value, 1 = read count.
REQ-009 cmd_data  in  32  compare value for load; ignored for read.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  result consumed when high with rsp_valid.
REQ-012 rsp_data  out  32  loaded value (load) or assembled count (read).
REQ-013 tmr_addr  out  3  timer byte address.
REQ-014 tmr_write  out  1  timer byte write strobe.
REQ-015 tmr_read  out  1  timer count-capture strobe.
REQ-016 tmr_wdata  out  8  timer write byte.
REQ-017 tmr_rdata  in  8  timer read byte, combinational on tmr_addr.
REQ-018 tmr_irq  in  1  timer interrupt level.
REQ-019 irq_pending  out  1  sticky interrupt flag.
REQ-020 irq_clear  in  1  clears irq_pending and irq_count.
REQ-021 irq_count  out  8  saturating count of tmr_irq rising edges since last clear.

Function
REQ-022 FSM states SHALL be IDLE, WR, RD_CAP, RD, RSP; cmd_ready SHALL be high only in IDLE.
REQ-023 Accepted load (cycle 0) SHALL enter WR; cycles 1..4 SHALL assert tmr_write with tmr_addr=WR_ADDR and tmr_wdata = cmd_data bytes [7:0],[15:8],[23:16],[31:24] in that order (LSB first).
REQ-024 Cycle 5 after load accept SHALL present rsp_valid with rsp_data = loaded value.
REQ-025 Accepted read (cycle 0) SHALL enter RD_CAP; cycle 1 SHALL assert tmr_read for exactly one cycle, tmr_addr=RD_BASE.
REQ-026 Cycles 2..5 SHALL drive tmr_addr RD_BASE..RD_BASE+3 and sample tmr_rdata into rsp_data bytes 0..3 at end of each cycle.
REQ-027 Cycle 6 after read accept SHALL present rsp_valid with the assembled 32-bit value.
REQ-028 In RSP, rsp_valid and rsp_data SHALL hold stable until rsp_ready; the handshake cycle SHALL return to IDLE; a new command SHALL not be accepted in the same cycle.
REQ-029 Outside WR, tmr_write SHALL be 0 and tmr_wdata 8'h00; outside RD_CAP, tmr_read SHALL be 0; in IDLE/RSP tmr_addr SHALL be 3'd0.
REQ-030 Beat counter SHALL be 2 bits and wrap 3->0 on leaving WR/RD.
REQ-031 irq_pending SHALL set on a registered rising edge of tmr_irq (0 previous, 1 current) and clear on irq_clear; simultaneous edge and clear SHALL leave it set.
REQ-032 irq_count SHALL increment per rising edge, saturate at 8'hFF, reset to 0 on irq_clear; simultaneous edge and clear SHALL yield 1.
REQ-033 IRQ tracking SHALL operate independently of FSM state.

Reset
REQ-034 With rst low at a clock edge: state IDLE, beat counter 0, cmd_ready 0 during reset then 1, rsp_valid 0, rsp_data 0, tmr_* outputs 0, irq_pending 0, irq_count 0, irq edge register 0.
REQ-035 Reset mid-load SHALL abandon remaining beats with no further tmr_write; a partially shifted timer compare value is accepted behaviour.

Structure
REQ-036 FSM state encoding and cmd_op encodings SHALL reside in the shared timer package; WR_ADDR/RD_BASE remain module parameters.
REQ-037 IRQ edge/sticky/counter logic SHALL be one sub-module, timer_irq_track.

Verification
REQ-038 Load 32'hA1B2C3D4 -> tmr_write cycles 1..4 with wdata D4,C3,B2,A1; rsp_valid cycle 5, rsp_data 32'hA1B2C3D4.
REQ-039 Read with timer count 32'h0000_1234 -> tmr_read cycle 1 only, addr 4,5,6,7 cycles 2..5, rsp_data 32'h0000_1234 cycle 6.
REQ-040 rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, cmd_ready 0, cmd_valid ignored.
REQ-041 Three tmr_irq pulses, then irq_clear coincident with a fourth edge -> count 3 before clear, then irq_pending 1, irq_count 1.
REQ-042 300 tmr_irq pulses -> irq_count 8'hFF; rst low during beat 2 of a load -> no further tmr_write, all outputs zero.
